// File: rtl/psum_gbf_accum.sv
// Partial-sum global buffer: 3-stage lane-wise read-modify-write accumulator with drain read port.
// Optional macro PSUM_GBF_SAT_EN: saturating lane adds plus sticky sat_flag output.

module psum_lane_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
`ifdef PSUM_GBF_SAT_EN
  output logic         sat_o,
`endif
  output logic [W-1:0] sum_o
);
`ifdef PSUM_GBF_SAT_EN
  logic [W:0] ext;
  logic       ovf;
  assign ext   = {a_i[W-1], a_i} + {b_i[W-1], b_i};
  assign ovf   = ext[W] ^ ext[W-1];
  assign sat_o = ovf;
  assign sum_o = !ovf ? ext[W-1:0] :
                 ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
  assign sum_o = a_i + b_i;
`endif
endmodule

module psum_gbf_accum #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int DEPTH             = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         psum_write_en,
  input  logic [9:0]                   psum_BRAM_addr,
  input  logic [GBF_DATA_BITWIDTH-1:0] out_data,
  input  logic                         clear,
  input  logic                         rd_en,
  input  logic [9:0]                   rd_addr,
  output logic                         rd_ready,
  output logic [GBF_DATA_BITWIDTH-1:0] rd_data,
  output logic                         rd_valid,
  output logic                         acc_busy
`ifdef PSUM_GBF_SAT_EN
  ,
  output logic                         sat_flag
`endif
);
  localparam int AW    = 10;
  localparam int DW    = DATA_BITWIDTH;
  localparam int GW    = GBF_DATA_BITWIDTH;
  localparam int LANES = GW / DW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  logic [GW-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vmap_q;
  logic [2:0]    vld_pipe_q;
  logic [AW-1:0] s0_addr_q, s1_addr_q, s2_addr_q;
  logic [GW-1:0] s0_data_q, s1_data_q, s1_old_q, s2_res_q;
  logic [GW-1:0] mem_rdata_q, s0_opnd, s1_sum;
  logic [AW-1:0] ridx;
  logic          wr_ok, wb_en, rd_acc;
  logic          rd_pend_q, rd_hit_q, rd_valid_q;
  logic [GW-1:0] rd_data_q;

  assign wr_ok    = psum_write_en && in_range(psum_BRAM_addr);
  assign wb_en    = vld_pipe_q[1] && !clear;
  assign acc_busy = |vld_pipe_q;
  assign rd_ready = !psum_write_en && !acc_busy;
  assign rd_acc   = rd_en && rd_ready;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // One shared read port: drains are only accepted when no write is sampled.
  assign ridx = psum_write_en ? (in_range(psum_BRAM_addr) ? psum_BRAM_addr : '0)
                              : (in_range(rd_addr) ? rd_addr : '0);

  always_ff @(posedge clk) begin
    mem_rdata_q <= mem[ridx];
    if (wb_en) mem[s1_addr_q] <= s1_sum;
  end

  // Younger in-flight result wins; an entry never written since clear reads as zero.
  always_comb begin
    s0_opnd = '0;
    if (vld_pipe_q[1] && s1_addr_q == s0_addr_q)      s0_opnd = s1_sum;
    else if (vld_pipe_q[2] && s2_addr_q == s0_addr_q) s0_opnd = s2_res_q;
    else if (vmap_q[s0_addr_q])                       s0_opnd = mem_rdata_q;
  end

`ifdef PSUM_GBF_SAT_EN
  logic [LANES-1:0] lane_sat;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    psum_lane_add #(.W(DW)) u_lane (
      .a_i   (s1_old_q[g*DW +: DW]),
      .b_i   (s1_data_q[g*DW +: DW]),
`ifdef PSUM_GBF_SAT_EN
      .sat_o (lane_sat[g]),
`endif
      .sum_o (s1_sum[g*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      s0_addr_q <= psum_BRAM_addr;
      s0_data_q <= out_data;
    end
    if (vld_pipe_q[0]) begin
      s1_addr_q <= s0_addr_q;
      s1_data_q <= s0_data_q;
      s1_old_q  <= s0_opnd;
    end
    if (vld_pipe_q[1]) begin
      s2_addr_q <= s1_addr_q;
      s2_res_q  <= s1_sum;
    end
  end

  // clear kills everything already in flight but keeps a write sampled with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      vmap_q     <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1] && !clear, vld_pipe_q[0] && !clear, wr_ok};
      if (clear)      vmap_q <= '0;
      else if (wb_en) vmap_q[s1_addr_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend_q  <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_pend_q  <= rd_acc;
      rd_hit_q   <= in_range(rd_addr) && vmap_q[ridx];
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) rd_data_q <= rd_hit_q ? mem_rdata_q : '0;
    end
  end

`ifdef PSUM_GBF_SAT_EN
  logic sat_q;
  assign sat_flag = sat_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     sat_q <= 1'b0;
    else if (clear)                 sat_q <= 1'b0;
    else if (wb_en && |lane_sat)    sat_q <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_psum_gbf_accum.sv
// Randomized + directed bench for psum_gbf_accum against a sequential-sum buffer model.
module tb_psum_gbf_accum;
  localparam int DW = 16, GW = 512, LN = 32, DEPTH = 1024;

  logic          clk = 0, reset = 1;
  logic          psum_write_en = 0, clear = 0, rd_en = 0;
  logic [9:0]    psum_BRAM_addr = '0, rd_addr = '0;
  logic [GW-1:0] out_data = '0;
  logic          rd_ready, rd_valid, acc_busy;
  logic [GW-1:0] rd_data;
`ifdef PSUM_GBF_SAT_EN
  logic          sat_flag;
`endif

  psum_gbf_accum dut (
    .clk(clk), .reset(reset), .psum_write_en(psum_write_en), .psum_BRAM_addr(psum_BRAM_addr),
    .out_data(out_data), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid), .acc_busy(acc_busy)
`ifdef PSUM_GBF_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // Reference: buffer contents as the plain sequential sum of all surviving writes.
  logic [GW-1:0] m_mem [DEPTH];
  bit            m_vld [DEPTH];
  int            edge_n = 0, last_wr = -100, last_clr = 0;
  bit            m_busy = 0, m_rv = 0, acc_now = 0, acc_prev = 0, m_sat = 0;
  logic [GW-1:0] m_rd = '0, m_rd_pend = '0;

  function automatic logic [GW-1:0] bcast(input logic [15:0] v);
    return {LN{v}};
  endfunction

  function automatic logic [GW-1:0] madd(input logic [GW-1:0] a, input logic [GW-1:0] b,
                                         output bit s);
    logic [GW-1:0] r;
    int x;
    s = 0;
    for (int i = 0; i < LN; i++) begin
      x = $signed(a[i*DW +: DW]) + $signed(b[i*DW +: DW]);
`ifdef PSUM_GBF_SAT_EN
      if (x > 32767) begin x = 32767; s = 1; end
      if (x < -32768) begin x = -32768; s = 1; end
`endif
      r[i*DW +: DW] = x[15:0];
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    bit s;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
      last_wr = -100; last_clr = 0; m_busy = 0; m_rv = 0; m_rd = '0;
      acc_now = 0; acc_prev = 0; m_sat = 0;
    end else begin
      edge_n++;
      acc_now = rd_en && !psum_write_en && !m_busy;
      m_rv = acc_prev;
      if (acc_prev) m_rd = m_rd_pend;
      if (acc_now) m_rd_pend = m_vld[rd_addr] ? m_mem[rd_addr] : '0;
      acc_prev = acc_now;
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
        m_sat = 0; last_clr = edge_n;
      end
      if (psum_write_en) begin
        if (m_vld[psum_BRAM_addr]) begin
          m_mem[psum_BRAM_addr] = madd(m_mem[psum_BRAM_addr], out_data, s);
          if (s) m_sat = 1;
        end else m_mem[psum_BRAM_addr] = out_data;
        m_vld[psum_BRAM_addr] = 1;
        last_wr = edge_n;
      end
      m_busy = (last_wr > edge_n - 3) && (last_wr >= last_clr);
    end
  end

  task automatic chk1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [GW-1:0] got, input logic [GW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk1("acc_busy", acc_busy, m_busy);
      chk1("rd_ready", rd_ready, !psum_write_en && !m_busy);
      chk1("rd_valid", rd_valid, m_rv);
      chkw("rd_data", rd_data, m_rd);
`ifdef PSUM_GBF_SAT_EN
      if (!m_busy) chk1("sat_flag", sat_flag, m_sat);
`endif
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [GW-1:0] d);
    psum_write_en = 1; psum_BRAM_addr = a; out_data = d;
    step;
    psum_write_en = 0;
  endtask

  task automatic rd_chk(input logic [9:0] a, input logic [GW-1:0] exp, input string nm);
    int n = 0;
    rd_addr = a; rd_en = 1;
    do begin step; n++; end while (!acc_now && n < 30);
    rd_en = 0;
    checks++;
    if (!acc_now) begin
      errs++;
      $display("FAIL %s_accept got=timeout exp=accepted", nm);
    end
    step;
    chk1({nm, "_valid"}, rd_valid, 1'b1);
    chkw(nm, rd_data, exp);
  endtask

  initial begin
    logic [GW-1:0] e;
    int cnt;
    #1 reset = 0;
    #2;
    chk1("rst_busy", acc_busy, 1'b0);
    chk1("rst_valid", rd_valid, 1'b0);
    chkw("rst_data", rd_data, '0);
`ifdef PSUM_GBF_SAT_EN
    chk1("rst_sat", sat_flag, 1'b0);
`endif
    repeat (3) @(posedge clk);
    #3 reset = 1;
    step;

    wr(10'd5, bcast(16'h0003));
    repeat (3) step;
    rd_chk(10'd5, bcast(16'h0003), "a5");
    rd_chk(10'd6, '0, "a6");

    cnt = 0;
    psum_write_en = 1; psum_BRAM_addr = 10'd7; out_data = bcast(16'h0001); step;
    if (acc_busy) cnt++;
    out_data = bcast(16'h0002); step;
    if (acc_busy) cnt++;
    out_data = bcast(16'h0004); step;
    psum_write_en = 0;
    for (int i = 0; i < 6; i++) begin
      if (acc_busy) cnt++;
      step;
    end
    checks++;
    if (cnt != 5) begin errs++; $display("FAIL busy_cycles got=%0d exp=5", cnt); end
    rd_chk(10'd7, bcast(16'h0007), "a7");

    wr(10'd1, bcast(16'h0010)); wr(10'd2, bcast(16'h0010));
    wr(10'd1, bcast(16'h0010)); wr(10'd2, bcast(16'h0010));
    rd_chk(10'd1, bcast(16'h0020), "a1");
    rd_chk(10'd2, bcast(16'h0020), "a2");

    e = '0; e[15:0] = 16'h7fff; wr(10'd10, e);
    e = '0; e[15:0] = 16'h0001; wr(10'd10, e);
    e = '0;
`ifdef PSUM_GBF_SAT_EN
    e[15:0] = 16'h7fff;
`else
    e[15:0] = 16'h8000;
`endif
    rd_chk(10'd10, e, "ovf");
`ifdef PSUM_GBF_SAT_EN
    chk1("sat_lit", sat_flag, 1'b1);
`endif

    psum_write_en = 1; psum_BRAM_addr = 10'd3; out_data = bcast(16'h0005); step;
    clear = 1; out_data = bcast(16'h0009); step;
    clear = 0; psum_write_en = 0;
    rd_chk(10'd3, bcast(16'h0009), "clr3");
    rd_chk(10'd5, '0, "clr5");
    rd_chk(10'd7, '0, "clr7");

    psum_write_en = 1; psum_BRAM_addr = 10'd8; out_data = bcast(16'h0002);
    step; step;
    #2 reset = 0; psum_write_en = 0;
    #1;
    chk1("mid_busy", acc_busy, 1'b0);
    chk1("mid_valid", rd_valid, 1'b0);
    chkw("mid_data", rd_data, '0);
    chk1("mid_ready", rd_ready, 1'b1);
    #1 reset = 1;
    step;
    rd_chk(10'd8, '0, "rst8");
    wr(10'd8, bcast(16'h0002));
    rd_chk(10'd8, bcast(16'h0002), "new8");

    for (int it = 0; it < 1500; it++) begin
      psum_write_en  = ($urandom_range(0, 2) != 0);
      psum_BRAM_addr = 10'($urandom_range(0, 15));
      for (int i = 0; i < LN; i++)
        out_data[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63) - 32);
      clear   = ($urandom_range(0, 49) == 0);
      rd_en   = ($urandom_range(0, 4) == 0);
      rd_addr = 10'($urandom_range(0, 15));
      step;
    end
    psum_write_en = 0; clear = 0; rd_en = 0;
    repeat (4) step;
    for (int a = 0; a < 16; a++) begin
      e = m_vld[a] ? m_mem[a] : '0;
      rd_chk(10'(a), e, "drain");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/psum_gbf_accum.md
Name: psum_gbf_accum

Overview:
- Responder/consumer side of the partial-sum write interface driven by the spatial-unrolling adder (out_data, psum_write_en, psum_BRAM_addr).
- Holds the psum global buffer. Every accepted write is read-modify-write accumulated lane-wise into the addressed entry.
- A drain read port lets the output/DRAM side read back final psums after a convolution.

Parameters:
- DATA_BITWIDTH, 16, width of one psum lane (signed two's complement)
- GBF_DATA_BITWIDTH, 512, width of one buffer entry; LANES = GBF_DATA_BITWIDTH/DATA_BITWIDTH (32)
- DEPTH, 1024, number of entries; must be less than or equal to 1024 (10-bit address)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- psum_write_en  in  1  write strobe from the adder; one write accepted per cycle, no backpressure
- psum_BRAM_addr  in  10  write entry address
- out_data  in  GBF_DATA_BITWIDTH  psum lanes to accumulate; lane i = bits [i*DATA_BITWIDTH +: DATA_BITWIDTH]
- clear  in  1  single-cycle pulse: start of new accumulation window
- rd_en  in  1  drain read request
- rd_addr  in  10  drain read address
- rd_ready  out  1  drain read may be accepted this cycle
- rd_data  out  GBF_DATA_BITWIDTH  drain read data
- rd_valid  out  1  rd_data valid (single-cycle pulse)
- acc_busy  out  1  one or more writes in flight

Behaviour:
- Reset (reset=0, async):
  - Pipeline valid bits cleared.
  - Per-entry valid bitmap cleared.
  - rd_data=0, rd_valid=0, acc_busy=0.
  - Memory array is not reset.
- Entry valid bitmap:
  - Entry with valid=0 reads as zero to both the accumulator and the drain port.
  - The first write after clear/reset stores out_data unchanged and sets valid.
- Write pipeline, 3 stages, throughput 1 per cycle:
  - S0 (edge T, psum_write_en=1): capture addr/data; issue memory read.
  - S1 (edge T+1): old value registered.
  - S2 (edge T+2): mem[addr] <= old + data, lane-wise; bitmap bit set.
  - A drain read accepted at edge T+3 or later sees the result.
- Forwarding:
  - If S0's address matches S1 or S2, the operand is the in-flight result, not the stale memory value (younger stage wins).
  - Result always equals the sequential sum of all writes to that address.
- Arithmetic:
  - Lane-wise DATA_BITWIDTH signed add; no carry between lanes.
  - Default wraps modulo 2^DATA_BITWIDTH.
- Address range: psum_BRAM_addr >= DEPTH is dropped; no state change.
- acc_busy = any of S0..S2 valid.
- Drain port:
  - rd_ready = !psum_write_en && !acc_busy.
  - rd_en with rd_ready=1 at edge T gives rd_data (entry value, or 0 if invalid or rd_addr >= DEPTH) and rd_valid=1 at T+1.
  - rd_en with rd_ready=0 is ignored; the requester must hold and retry.
  - rd_data holds its last value when rd_valid=0.
- clear:
  - Synchronously zeroes the bitmap and discards (suppresses writeback of) all in-flight S1/S2 ops.
  - A write sampled in the same cycle as clear is kept and treated as a first write.
  - clear does not affect a drain read in flight; rd_valid still pulses.
- Reset mid-operation: in-flight writes are lost; memory contents are stale but invisible, because the bitmap is cleared.

Optional Feature:
- Macro PSUM_GBF_SAT_EN.
- Defined: each lane add saturates to [-2^(DATA_BITWIDTH-1), 2^(DATA_BITWIDTH-1)-1]. Adds output sat_flag (1 bit), sticky, set on any saturating lane, cleared by reset or clear.
- Undefined: wrap-around add, no sat_flag port.

Test Plan:
- Reset, then write addr 5 with all lanes 0x0003, wait 3 cycles, drain read addr 5 -> rd_valid at next cycle, all lanes 0x0003; drain read addr 6 -> all lanes 0x0000.
- Back-to-back writes to addr 7, lanes 0x0001, then 0x0002, then 0x0004, on consecutive cycles -> acc_busy high 5 cycles; drain read addr 7 -> all lanes 0x0007 (exercises forwarding from S1 and S2).
- Interleaved writes A,B,A,B (addr 1/2, data 0x0010 each) -> addr 1 = addr 2 = 0x0020 per lane; rd_ready low while psum_write_en or acc_busy high.
- Lane 0 = 0x7FFF plus 0x0001, other lanes 0x0000 -> without macro lane0 = 0x8000, lanes 1..31 = 0; with PSUM_GBF_SAT_EN lane0 = 0x7FFF, sat_flag = 1.
- Write addr 3 = 0x0005, then clear in the same cycle as a write of 0x0009 to addr 3 while the first write is still in flight -> addr 3 reads 0x0009 per lane; other previously written entries read 0.
- Assert reset low mid-burst of writes to addr 8 -> all outputs 0 immediately; after release, addr 8 reads 0; new write of 0x0002 reads back 0x0002.
